// File: rtl/fsm_w_recover.sv
// Recovers the w input of the six-state one-hot FSM from its state trace.
// Ports: clk, reset (sync, active-high), y[5:0], y_valid -> w_out, w_valid,
//        illegal, locked, err_cnt[7:0]. All outputs are registered.
module fsm_w_recover (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] y,
    input  logic       y_valid,
    output logic       w_out,
    output logic       w_valid,
    output logic       illegal,
    output logic       locked,
    output logic [7:0] err_cnt
);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    localparam logic [5:0] ST_A = 6'b000001;
    localparam logic [5:0] ST_B = 6'b000010;
    localparam logic [5:0] ST_C = 6'b000100;
    localparam logic [5:0] ST_D = 6'b001000;
    localparam logic [5:0] ST_E = 6'b010000;
    localparam logic [5:0] ST_F = 6'b100000;

    logic [0:0] r_state;
    logic [5:0] r_prev;
    logic       r_w_out;
    logic       r_w_valid;
    logic       r_illegal;
    logic [7:0] r_err_cnt;

    logic       w_onehot;
    logic [5:0] w_dst0;
    logic [5:0] w_dst1;
    logic       w_legal;
    logic       w_bit;
    logic [7:0] w_err_next;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_onehot = (y != 6'd0) && ((y & (y - 6'd1)) == 6'd0);

    // Successor states of prev for w=0 and w=1.
    always_comb begin
        w_dst0 = 6'd0;
        w_dst1 = 6'd0;
        unique case (1'b1)
            r_prev[0]: begin w_dst0 = ST_A; w_dst1 = ST_B; end
            r_prev[1]: begin w_dst0 = ST_D; w_dst1 = ST_C; end
            r_prev[2]: begin w_dst0 = ST_D; w_dst1 = ST_E; end
            r_prev[3]: begin w_dst0 = ST_A; w_dst1 = ST_F; end
            r_prev[4]: begin w_dst0 = ST_D; w_dst1 = ST_E; end
            r_prev[5]: begin w_dst0 = ST_D; w_dst1 = ST_C; end
            default:   begin w_dst0 = 6'd0; w_dst1 = 6'd0; end
        endcase
    end

    // The two destinations always differ, so a match on dst1 means w=1.
    assign w_legal    = (y == w_dst0) || (y == w_dst1);
    assign w_bit      = (y == w_dst1);
    assign w_err_next = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= UNLOCKED;
            r_prev    <= 6'd0;
            r_w_out   <= 1'b0;
            r_w_valid <= 1'b0;
            r_illegal <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_w_valid <= 1'b0;
            r_illegal <= 1'b0;
            if (y_valid) begin
                if (!w_onehot) begin
                    r_illegal <= 1'b1;
                    r_err_cnt <= w_err_next;
                    r_state   <= UNLOCKED;
                end else if (r_state == UNLOCKED) begin
                    r_prev  <= y;
                    r_state <= LOCKED;
                end else if (w_legal) begin
                    r_w_valid <= 1'b1;
                    r_w_out   <= w_bit;
                    r_prev    <= y;
                end else begin
                    // Impossible step: flag it but resync onto the new state.
                    r_illegal <= 1'b1;
                    r_err_cnt <= w_err_next;
                    r_prev    <= y;
                end
            end
        end
    end

    assign w_out   = r_w_out;
    assign w_valid = r_w_valid;
    assign illegal = r_illegal;
    assign locked  = (r_state == LOCKED);
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fsm_w_recover.sv
// Scoreboard bench for fsm_w_recover: directed state traces with
// hand-computed w / illegal / err_cnt / locked expectations.
module tb_fsm_w_recover;

    logic       clk;
    logic       reset;
    logic [5:0] y;
    logic       y_valid;
    logic       w_out;
    logic       w_valid;
    logic       illegal;
    logic       locked;
    logic [7:0] err_cnt;

    typedef struct packed {
        logic       ill;
        logic       w;
        logic [7:0] err;
        logic       lock;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    fsm_w_recover dut (
        .clk    (clk),
        .reset  (reset),
        .y      (y),
        .y_valid(y_valid),
        .w_out  (w_out),
        .w_valid(w_valid),
        .illegal(illegal),
        .locked (locked),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation for every pulse the DUT presents.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (w_valid || illegal) begin
            total++;
            if (w_valid && illegal) begin
                bad++;
                $display("FAIL both_pulses: w_valid=1 illegal=1");
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: w_valid=%0b illegal=%0b", w_valid, illegal);
            end else begin
                e = q.pop_front();
                if (illegal != e.ill || w_valid == e.ill ||
                    (!e.ill && w_out != e.w) ||
                    err_cnt != e.err || locked != e.lock) begin
                    bad++;
                    $display("FAIL pulse: got ill=%0b w=%0b err=%0d lock=%0b need ill=%0b w=%0b err=%0d lock=%0b",
                             illegal, w_out, err_cnt, locked, e.ill, e.w, e.err, e.lock);
                end
            end
        end
    end

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s: got %h need %h", name, got, need);
        end
    endtask

    // kind: 0 = relock only (nothing expected), 1 = w pulse, 2 = illegal pulse
    task automatic send(input logic [5:0] yv, input int kind, input logic wv,
                        input logic [7:0] ev, input logic lv);
        exp_t e;
        @(negedge clk);
        y       = yv;
        y_valid = 1'b1;
        if (kind != 0) begin
            e.ill  = (kind == 2);
            e.w    = wv;
            e.err  = ev;
            e.lock = lv;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        y_valid = 1'b0;
        y       = 6'd0;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        y_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {w_out, w_valid, illegal, locked, err_cnt},
              {4'b0000, 8'd0});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] ys [10];
        logic       ws [10];
        reset   = 1'b1;
        y       = 6'd0;
        y_valid = 1'b0;
        do_reset();

        // Clean trace A,B,C,E,E,D,F,C,D,A
        ys = '{6'h01, 6'h02, 6'h04, 6'h10, 6'h10, 6'h08, 6'h20, 6'h04, 6'h08, 6'h01};
        ws = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        send(ys[0], 0, 1'b0, 8'd0, 1'b1);
        #1 check("lock_first", {11'd0, locked}, 12'd1);
        for (int i = 1; i < 10; i++) send(ys[i], 1, ws[i], 8'd0, 1'b1);
        idle(2);
        check("clean_err", {4'd0, err_cnt}, 12'd0);

        // Impossible A->D, then legal D->A
        do_reset();
        send(6'h01, 0, 1'b0, 8'd0, 1'b1);
        send(6'h08, 2, 1'b0, 8'd1, 1'b1);
        send(6'h01, 1, 1'b0, 8'd1, 1'b1);

        // Non-one-hot drops lock, then relock and decode
        do_reset();
        send(6'h01, 0, 1'b0, 8'd0, 1'b1);
        send(6'h03, 2, 1'b0, 8'd1, 1'b0);
        send(6'h00, 2, 1'b0, 8'd2, 1'b0);
        send(6'h02, 0, 1'b0, 8'd2, 1'b1);
        #1 check("relock", {4'd0, locked, err_cnt[6:0]}, {4'd0, 1'b1, 7'd2});
        send(6'h04, 1, 1'b1, 8'd2, 1'b1);

        // Gaps in y_valid
        do_reset();
        send(6'h01, 0, 1'b0, 8'd0, 1'b1);
        send(6'h02, 1, 1'b1, 8'd0, 1'b1);
        idle(3);
        send(6'h08, 1, 1'b0, 8'd0, 1'b1);
        idle(2);

        // Saturating error count
        do_reset();
        for (int i = 0; i < 260; i++)
            send(6'h3F, 2, 1'b0, (i >= 254) ? 8'd255 : 8'(i + 1), 1'b0);
        idle(2);
        check("err_sat", {4'd0, err_cnt}, 12'd255);

        // Reset overriding a valid sample mid-stream
        do_reset();
        send(6'h01, 0, 1'b0, 8'd0, 1'b1);
        send(6'h02, 1, 1'b1, 8'd0, 1'b1);
        @(negedge clk);
        reset   = 1'b1;
        y       = 6'h01;
        y_valid = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset", {w_out, w_valid, illegal, locked, err_cnt},
              {4'b0000, 8'd0});
        @(negedge clk);
        reset   = 1'b0;
        y_valid = 1'b0;
        send(6'h02, 0, 1'b0, 8'd0, 1'b1);
        #1 check("relock_after_reset", {11'd0, locked}, 12'd1);
        send(6'h04, 1, 1'b1, 8'd0, 1'b1);
        idle(3);

        check("queue_drained", 12'(q.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
